reg_file_sb: RTL and testbench

- Parametrised successor to the single-cycle CPU register file, for the pipelined/multi-cycle core.
- Provides 2 combinational read ports and 1 synchronous write port.
- Performs load-result sign/zero extension on writeback, selected by funct3.
- Adds a per-register scoreboard that tracks outstanding load destinations and raises a hazard/stall for the issue stage.

---
 rtl/reg_file_sb.sv | 106 ++++++++++
 tb/tb_reg_file_sb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file: 2 combinational read ports, 1 write port with load extension, and a scoreboard
// of pending load destinations. Define REG_FILE_SB_BYPASS_EN for write-through forwarding.
module reg_file_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_WIDTH-1:0]         rd_addr1,
  input  logic [ADDR_WIDTH-1:0]         rd_addr2,
  output logic [DATA_WIDTH-1:0]         rd_data1,
  output logic [DATA_WIDTH-1:0]         rd_data2,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_ld,
  input  logic [2:0]                    wr_funct3,
  input  logic                          issue_en,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  output logic                          hazard,
  output logic [(2**ADDR_WIDTH)-1:0]    busy,
  output logic [ADDR_WIDTH:0]           pending_cnt
);
  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [NumRegs-1:0]    busy_q, busy_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  wr_hit;
  logic [DATA_WIDTH-1:0] wr_ext;

  function automatic logic [DATA_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] d,
                                                input logic ld, input logic [2:0] f3);
    if (!ld) return d;
    case (f3)
      3'b000:  return {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
      3'b001:  return {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
      3'b100:  return {{(DATA_WIDTH-8){1'b0}}, d[7:0]};
      3'b101:  return {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign wr_hit = wr_en && (wr_addr != '0);
  assign wr_ext = ext(wr_data, wr_ld, wr_funct3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[wr_addr] <= wr_ext;
    end
  end

  // Issue is applied after writeback clear so a same-cycle re-issue keeps the register pending.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    if (wr_hit) busy_d[wr_addr] = 1'b0;
    if (issue_en && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    for (int r = 0; r < NumRegs; r++) cnt_d = cnt_d + (ADDR_WIDTH+1)'(busy_d[r]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign pending_cnt = cnt_q;

  logic hz1, hz2;

  always_comb begin
    rd_data1 = (rd_addr1 == '0) ? '0 : regs_q[rd_addr1];
    rd_data2 = (rd_addr2 == '0) ? '0 : regs_q[rd_addr2];
    hz1      = busy_q[rd_addr1] && (rd_addr1 != '0);
    hz2      = busy_q[rd_addr2] && (rd_addr2 != '0);
`ifdef REG_FILE_SB_BYPASS_EN
    // A completing load clears its stall now unless the same register is re-issued this cycle.
    if (wr_hit && (rd_addr1 == wr_addr)) begin
      rd_data1 = wr_ext;
      hz1      = issue_en && (issue_rd == wr_addr);
    end
    if (wr_hit && (rd_addr2 == wr_addr)) begin
      rd_data2 = wr_ext;
      hz2      = issue_en && (issue_rd == wr_addr);
    end
`endif
    if (reset) begin
      rd_data1 = '0;
      rd_data2 = '0;
      hz1      = 1'b0;
      hz2      = 1'b0;
    end
  end

  assign hazard = hz1 || hz2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized self-checking bench for reg_file_sb against a behavioural model, with pinned
// literal expectations for the directed scenarios.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, issue_rd = '0;
  logic [31:0] rd_data1, rd_data2, wr_data = '0;
  logic        wr_en = 1'b0, wr_ld = 1'b0, issue_en = 1'b0;
  logic [2:0]  wr_funct3 = '0;
  logic        hazard;
  logic [31:0] busy;
  logic [5:0]  pending_cnt;

  reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ld(wr_ld), .wr_funct3(wr_funct3), .issue_en(issue_en),
    .issue_rd(issue_rd), .hazard(hazard), .busy(busy), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

`ifdef REG_FILE_SB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  // Behavioural model: register values and a set of pending registers.
  logic [31:0] m_regs [32];
  bit          m_pend [32];

  function automatic logic [31:0] m_ext(input logic [31:0] d, input logic ld,
                                        input logic [2:0] f3);
    logic [31:0] b, h;
    b = d & 32'h0000_00FF;
    h = d & 32'h0000_FFFF;
    if (!ld) return d;
    if (f3 == 3'd0) return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
    if (f3 == 3'd1) return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
    if (f3 == 3'd4) return b;
    if (f3 == 3'd5) return h;
    return d;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] <= 32'd0;
        m_pend[i] <= 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] <= m_ext(wr_data, wr_ld, wr_funct3);
        m_pend[wr_addr] <= 1'b0;
      end
      if (issue_en && issue_rd != 0) m_pend[issue_rd] <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (reset || a == 0) return 32'd0;
    if (Bypass && wr_en && wr_addr == a) return m_ext(wr_data, wr_ld, wr_funct3);
    return m_regs[a];
  endfunction

  function automatic bit exp_term(input logic [4:0] a);
    if (reset || a == 0) return 1'b0;
    if (Bypass && wr_en && wr_addr == a) return issue_en && issue_rd == a;
    return m_pend[a];
  endfunction

  int n_chk = 0;
  int n_fail = 0;
  bit check_on = 1'b0;
  bit pin_rd1_en = 0, pin_rd2_en = 0, pin_hz_en = 0, pin_cnt_en = 0;
  logic [31:0] pin_rd1, pin_rd2, pin_cnt;
  logic        pin_hz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_on) begin
      logic [31:0] eb;
      int          ec;
      eb = '0;
      ec = 0;
      for (int i = 1; i < 32; i++) if (m_pend[i]) begin eb[i] = 1'b1; ec++; end
      chk("rd_data1", rd_data1, exp_rd(rd_addr1));
      chk("rd_data2", rd_data2, exp_rd(rd_addr2));
      chk("hazard", {31'd0, hazard}, {31'd0, exp_term(rd_addr1) || exp_term(rd_addr2)});
      chk("busy", busy, eb);
      chk("pending_cnt", {26'd0, pending_cnt}, 32'(ec));
      if (pin_rd1_en) chk("pin_rd_data1", rd_data1, pin_rd1);
      if (pin_rd2_en) chk("pin_rd_data2", rd_data2, pin_rd2);
      if (pin_hz_en)  chk("pin_hazard", {31'd0, hazard}, {31'd0, pin_hz});
      if (pin_cnt_en) chk("pin_pending_cnt", {26'd0, pending_cnt}, pin_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_ld = 0; wr_funct3 = 0; wr_addr = 0; wr_data = 0;
    issue_en = 0; issue_rd = 0;
  endtask

  task automatic unpin();
    pin_rd1_en = 0; pin_rd2_en = 0; pin_hz_en = 0; pin_cnt_en = 0;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d, input logic ld,
                       input logic [2:0] f3);
    wr_en = 1; wr_addr = a; wr_data = d; wr_ld = ld; wr_funct3 = f3;
  endtask

  logic [2:0]  f3_tab  [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b111};
  logic [31:0] ext_tab [6] = '{32'hFFFF_FF80, 32'hFFFF_8F80, 32'h0000_0080,
                               32'h0000_8F80, 32'h0000_8F80, 32'h0000_8F80};

  initial begin
    tick();
    check_on = 1'b1;
    pin_cnt_en = 1; pin_cnt = 0; pin_rd1_en = 1; pin_rd1 = 0;
    tick();
    #2 reset = 1'b0;
    unpin();
    tick();

    // Load extension into x3
    for (int k = 0; k < 6; k++) begin
      write(5'd3, 32'h0000_8F80, 1'b1, f3_tab[k]);
      tick();
      idle(); rd_addr1 = 5'd3; pin_rd1_en = 1; pin_rd1 = ext_tab[k];
      tick();
      unpin();
    end

    // x0 is immune to writes and issues
    write(5'd0, 32'hDEAD_BEEF, 1'b0, 3'd0); issue_en = 1; issue_rd = 5'd0; rd_addr1 = 0;
    tick();
    idle(); pin_rd1_en = 1; pin_rd1 = 0; pin_cnt_en = 1; pin_cnt = 0;
    tick(); unpin();

    // Hazard on x7 and its writeback
    issue_en = 1; issue_rd = 5'd7;
    tick();
    idle(); rd_addr1 = 5'd7; pin_hz_en = 1; pin_hz = 1; pin_cnt_en = 1; pin_cnt = 1;
    tick();
    write(5'd7, 32'h55, 1'b0, 3'd0);
    pin_hz = !Bypass; pin_rd1_en = 1; pin_rd1 = Bypass ? 32'h55 : 32'h0;
    tick();
    idle(); pin_hz = 0; pin_rd1 = 32'h55; pin_cnt = 0;
    tick(); unpin();

    // Same-cycle clear and re-issue on x9
    issue_en = 1; issue_rd = 5'd9;
    tick();
    write(5'd9, 32'h1234_5678, 1'b0, 3'd0); issue_en = 1; issue_rd = 5'd9;
    tick();
    idle(); rd_addr1 = 5'd9; pin_hz_en = 1; pin_hz = 1; pin_cnt_en = 1; pin_cnt = 1;
    pin_rd1_en = 1; pin_rd1 = 32'h1234_5678;
    tick(); unpin();
    write(5'd9, 32'h0, 1'b0, 3'd0);
    tick(); idle();

    // Load writeback to busy x4 observed on port 2
    issue_en = 1; issue_rd = 5'd4; rd_addr1 = 0;
    tick();
    idle(); rd_addr2 = 5'd4; write(5'd4, 32'hA5, 1'b1, 3'b000);
    pin_rd2_en = 1; pin_rd2 = Bypass ? 32'hFFFF_FFA5 : 32'h0;
    pin_hz_en = 1; pin_hz = !Bypass;
    tick(); unpin(); idle();
    tick();

    // Asynchronous reset between edges
    write(5'd5, 32'h1234, 1'b0, 3'd0);
    tick();
    idle(); issue_en = 1; issue_rd = 5'd6;
    tick();
    idle(); rd_addr1 = 5'd5; rd_addr2 = 5'd6;
    #1 reset = 1'b1;
    pin_rd1_en = 1; pin_rd1 = 0; pin_hz_en = 1; pin_hz = 0; pin_cnt_en = 1; pin_cnt = 0;
    tick();
    #1 reset = 1'b0;
    unpin();
    tick();

    // Randomized traffic, addresses biased to a small window for collisions
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] lim;
      lim = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
      wr_en     = ($urandom_range(0, 2) != 0);
      wr_addr   = 5'($urandom_range(0, 32'(lim)));
      wr_data   = $urandom;
      wr_ld     = 1'($urandom_range(0, 1));
      wr_funct3 = 3'($urandom_range(0, 7));
      issue_en  = ($urandom_range(0, 1) != 0);
      issue_rd  = 5'($urandom_range(0, 32'(lim)));
      rd_addr1  = 5'($urandom_range(0, 32'(lim)));
      rd_addr2  = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 32'(lim)));
      tick();
    end
    idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
